// File: rtl/instruction_encoder_if.sv
// Field-bundle input channel and instruction-memory write channel of the encoder.
interface instruction_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        op;
  logic [5:0]        func;
  logic [4:0]        src1;
  logic [4:0]        src2;
  logic [4:0]        dest;
  logic [15:0]       imm;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              done;
  logic              illegal;

  modport slave (
    input  start, in_valid, in_last, op, func, src1, src2, dest, imm, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, done, illegal
  );

  modport master (
    output start, in_valid, in_last, op, func, src1, src2, dest, imm, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, done, illegal
  );
endinterface

// File: rtl/instruction_encoder.sv
// Packs op/func/register/immediate fields into MIPS words and streams them to
// instruction memory at sequential addresses during a load session.
module instruction_encoder #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_encoder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic              legal;
  logic [31:0]       word;
  logic              accept;
  logic              load_word;
  logic              wrap;

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    legal = 1'b0;
    word  = '0;
    if (bus.op == 6'h00) begin
      if (bus.func == 6'h00) begin
        legal = 1'b1;
        word  = {6'h00, 5'd0, bus.src1, bus.dest, bus.src2, 6'h00};
      end else if (bus.func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
        legal = 1'b1;
        word  = {6'h00, bus.src1, bus.src2, bus.dest, 5'd0, bus.func};
      end
    end else if (bus.op inside {6'h23, 6'h2B, 6'h08, 6'h04, 6'h05}) begin
      legal = 1'b1;
      word  = {bus.op, bus.src1, bus.dest, bus.imm};
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = (state == LOAD) && (!bus.wr_en || bus.wr_ready);
    bus.done     = (state == DONE);
    accept       = bus.in_valid && bus.in_ready;
    load_word    = accept && legal;
    // A legal word whose successor address is the base would overwrite the first word.
    wrap         = load_word && (cnt_inc == BASE_ADDR);
    unique case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  if (accept && (bus.in_last || wrap)) state_nxt = DRAIN;
      DRAIN: if (!bus.wr_en) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= BASE_ADDR;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= BASE_ADDR;
      bus.wr_data <= '0;
      bus.illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        cnt         <= BASE_ADDR;
        bus.illegal <= 1'b0;
      end
      // Loading a new word takes priority over draining, giving one word per cycle.
      if (load_word) begin
        bus.wr_en   <= 1'b1;
        bus.wr_addr <= cnt;
        bus.wr_data <= word;
        cnt         <= cnt_inc;
      end else if (bus.wr_ready) begin
        bus.wr_en <= 1'b0;
      end
      if (accept && !legal) bus.illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: a driver pushes expected writes from
// a field-level reference model, a negedge monitor pops and compares.
module tb_instruction_encoder;
  localparam int AW = 6;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic        last;
  } bundle_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk;
  logic reset;
  instruction_encoder_if #(.ADDR_W(AW)) bus ();

  instruction_encoder #(.ADDR_W(AW), .BASE_ADDR('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  checks = 0;
  int  failures = 0;
  int  done_seen = 0;
  int  sessions = 0;
  int  ready_mode = 0;
  int  m_cnt = 0;
  bit  m_illegal = 0;
  wr_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoding from the field placement rules, as shifted sums.
  function automatic bit model(input bundle_t b, output logic [31:0] w);
    w = 32'd0;
    if (b.op == 0 && b.func == 0) begin
      w = (32'(b.src1) << 16) | (32'(b.dest) << 11) | (32'(b.src2) << 6);
      return 1'b1;
    end
    if (b.op == 0 && (b.func == 6'h20 || b.func == 6'h22 || b.func == 6'h24 ||
                      b.func == 6'h25 || b.func == 6'h2A)) begin
      w = (32'(b.src1) << 21) | (32'(b.src2) << 16) | (32'(b.dest) << 11) | 32'(b.func);
      return 1'b1;
    end
    if (b.op == 6'h23 || b.op == 6'h2B || b.op == 6'h08 || b.op == 6'h04 || b.op == 6'h05) begin
      w = (32'(b.op) << 26) | (32'(b.src1) << 21) | (32'(b.dest) << 16) | 32'(b.imm);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bundle_t mk(input int op, input int func, input int s1, input int s2,
                                 input int d, input int imm, input bit last);
    bundle_t b;
    b.op = 6'(op); b.func = 6'(func); b.src1 = 5'(s1); b.src2 = 5'(s2);
    b.dest = 5'(d); b.imm = 16'(imm); b.last = last;
    return b;
  endfunction

  function automatic bundle_t rand_bundle(input bit last);
    bundle_t b;
    logic [5:0] rfuncs [6];
    logic [5:0] iops [5];
    rfuncs = '{6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    iops   = '{6'h23, 6'h2B, 6'h08, 6'h04, 6'h05};
    b = bundle_t'({$urandom, $urandom});
    b.last = last;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: begin b.op = 6'h00; b.func = rfuncs[$urandom_range(0, 5)]; end
      4, 5, 6, 7: b.op = iops[$urandom_range(0, 4)];
      8:          b.op = 6'h00;
      default:    ;
    endcase
    return b;
  endfunction

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.wr_ready = 1'b1;
        1: bus.wr_ready = ($urandom_range(0, 2) != 0);
        default: bus.wr_ready = 1'b0;
      endcase
    end
  end

  bit            prev_hold = 0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_wr_en", 32'(bus.wr_en), 32'd1);
        chk("hold_wr_addr", 32'(bus.wr_addr), 32'(prev_addr));
        chk("hold_wr_data", bus.wr_data, prev_data);
      end
      if (bus.wr_en && !bus.wr_ready) chk("backpressure_in_ready", 32'(bus.in_ready), 32'd0);
      if (bus.wr_en && bus.wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected", bus.wr_addr, bus.wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", bus.wr_data, e.data);
        end
      end
      if (bus.done) done_seen++;
      prev_hold = bus.wr_en && !bus.wr_ready;
      prev_addr = bus.wr_addr;
      prev_data = bus.wr_data;
    end
  end

  task automatic start_session();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_cnt = 0;
    m_illegal = 0;
    chk("illegal_cleared_on_start", 32'(bus.illegal), 32'd0);
  endtask

  task automatic send(input bundle_t b, input bit lit_ok, input logic [31:0] lit, output bit ended);
    bit acc;
    logic [31:0] w;
    bit ok;
    wr_t e;
    ended = 0;
    bus.op = b.op; bus.func = b.func; bus.src1 = b.src1; bus.src2 = b.src2;
    bus.dest = b.dest; bus.imm = b.imm; bus.in_last = b.last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        ok = model(b, w);
        if (lit_ok) w = lit;
        if (ok) begin
          e.addr = AW'(m_cnt);
          e.data = w;
          exp_q.push_back(e);
          m_cnt = (m_cnt + 1) % (1 << AW);
          if (m_cnt == 0) ended = 1;
        end else begin
          m_illegal = 1;
        end
        if (b.last) ended = 1;
        return;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    failures++;
    $display("FAIL accept_timeout: bundle op 0x%02h never accepted", b.op);
  endtask

  task automatic wait_done(output int edges);
    bit found;
    found = 0;
    edges = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        break;
      end
      chk("in_ready_after_end", 32'(bus.in_ready), 32'd0);
      edges++;
    end
    chk("done_seen", 32'(found), 32'd1);
    sessions++;
    chk("illegal_at_done", 32'(bus.illegal), 32'(m_illegal));
    chk("all_words_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ended;
    int edges;
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.op = '0; bus.func = '0; bus.src1 = '0; bus.src2 = '0; bus.dest = '0; bus.imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single ADD with in_last, done two cycles after the word appears
    ready_mode = 0;
    start_session();
    send(mk(0, 6'h20, 1, 2, 3, 0, 1), 1, 32'h00221820, ended);
    wait_done(edges);
    chk("add_done_latency", 32'(edges), 32'd2);

    // SLL then LW
    start_session();
    send(mk(0, 6'h00, 1, 4, 2, 0, 0), 1, 32'h00011100, ended);
    send(mk(6'h23, 0, 29, 0, 8, 16'h0010, 1), 1, 32'h8FA80010, ended);
    wait_done(edges);

    // backpressure held for three cycles with a bundle waiting
    start_session();
    ready_mode = 2;
    send(mk(0, 6'h20, 5, 6, 7, 0, 0), 0, 32'd0, ended);
    fork
      send(mk(0, 6'h22, 8, 9, 10, 0, 0), 0, 32'd0, ended);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        ready_mode = 0;
      end
    join
    send(mk(0, 6'h25, 11, 12, 13, 0, 1), 0, 32'd0, ended);
    wait_done(edges);

    // illegal op between two ADDs
    ready_mode = 1;
    start_session();
    send(mk(0, 6'h20, 1, 1, 1, 0, 0), 0, 32'd0, ended);
    send(mk(6'h3F, 0, 2, 2, 2, 16'h1234, 0), 0, 32'd0, ended);
    send(mk(0, 6'h20, 3, 3, 3, 0, 1), 0, 32'd0, ended);
    wait_done(edges);

    // lone illegal bundle carrying in_last
    ready_mode = 0;
    start_session();
    send(mk(0, 6'h3F, 1, 2, 3, 0, 1), 0, 32'd0, ended);
    wait_done(edges);
    chk("illegal_last_done_latency", 32'(edges), 32'd1);

    // fill the whole address space without in_last; wrap ends the session
    ready_mode = 1;
    start_session();
    for (int i = 0; i < (1 << AW); i++) begin
      send(mk(6'h08, 0, $urandom_range(0, 31), 0, $urandom_range(0, 31), $urandom, 0), 0, 32'd0, ended);
      chk("wrap_end_flag", 32'(ended), 32'(i == (1 << AW) - 1));
    end
    bus.op = 6'h08; bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    wait_done(edges);
    bus.in_valid = 1'b0;

    // randomized sessions, with stray start pulses mid-session
    for (int s = 0; s < 10; s++) begin
      ready_mode = (s % 3 == 0) ? 0 : 1;
      start_session();
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        if (k != n - 1 && $urandom_range(0, 3) == 0) bus.start = 1'b1;
        send(rand_bundle(k == n - 1), 0, 32'd0, ended);
        bus.start = 1'b0;
      end
      wait_done(edges);
    end

    // reset with a word pending toward memory
    ready_mode = 2;
    start_session();
    send(mk(0, 6'h2A, 4, 5, 6, 0, 0), 0, 32'd0, ended);
    @(negedge clk);
    chk("pending_before_reset", 32'(bus.wr_en), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_wr_data", bus.wr_data, 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_illegal", 32'(bus.illegal), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    ready_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_after_abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("done_pulse_count", 32'(done_seen), 32'(sessions));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
